// File: rtl/seq_detect_param_if.sv
// Bus bundle for the parametrised serial sequence detector: stream input,
// pattern load controls and the match/status outputs.
interface seq_detect_param_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             load;
    logic [N-1:0]     pattern_in;
    logic             overlap_in;
    logic             seq_valid;
    logic             seq;
    logic             dout;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;
    logic             armed;

    // Bit source / controller side
    modport master (
        output en, load, pattern_in, overlap_in, seq_valid, seq,
        input  dout, match_cnt, cnt_sat, armed
    );

    // Detector side
    modport slave (
        input  en, load, pattern_in, overlap_in, seq_valid, seq,
        output dout, match_cnt, cnt_sat, armed
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector. A run-time loaded N-bit pattern is
// compared against a shift window of qualified input bits; each match gives a
// one-cycle registered pulse and bumps a saturating counter. Overlapping or
// non-overlapping detection is chosen at load time.
module seq_detect_param #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    seq_detect_param_if.slave   bus
);
    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] N_F = FW'(N);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        HUNT = 2'b10
    } state_t;

    state_t           state_q;
    logic [N-1:0]     pattern_q;
    logic [N-1:0]     window_q;
    logic [FW-1:0]    fill_q;
    logic             overlap_q;
    logic             dout_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic             armed_q;

    logic             accept_s;
    logic [N-1:0]     win_shift_s;
    logic [FW-1:0]    fill_inc_s;
    logic             full_s;
    logic             hit_s;
    logic [CNT_W-1:0] cnt_d;
    logic             sat_d;

    // Saturating increment: an all-ones counter stays put
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    // Decode of the bit being accepted this cycle and whether it completes a match
    always_comb begin
        accept_s    = 1'b0;
        win_shift_s = {window_q[N-2:0], bus.seq};
        fill_inc_s  = fill_q + FW'(1);
        full_s      = 1'b0;
        hit_s       = 1'b0;
        cnt_d       = sat_inc(cnt_q);
        sat_d       = (cnt_d == {CNT_W{1'b1}});
        if (bus.en && bus.seq_valid && !bus.load && (state_q != IDLE)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if ((state_q == HUNT) || (fill_inc_s == N_F)) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
        if (accept_s && full_s && (win_shift_s == pattern_q)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Detector FSM: load, window shift, fill tracking, match pulse and counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            window_q  <= '0;
            fill_q    <= '0;
            overlap_q <= 1'b0;
            dout_q    <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            armed_q   <= 1'b0;
        end else if (bus.load) begin
            // Load wins over any bit presented in the same cycle
            state_q   <= FILL;
            pattern_q <= bus.pattern_in;
            overlap_q <= bus.overlap_in;
            window_q  <= '0;
            fill_q    <= '0;
            dout_q    <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            armed_q   <= 1'b1;
        end else if (accept_s) begin
            window_q <= win_shift_s;
            if (hit_s) begin
                dout_q <= 1'b1;
                cnt_q  <= cnt_d;
                sat_q  <= sat_d;
                if (overlap_q) begin
                    // Keep the window so its tail can start the next match
                    state_q <= HUNT;
                    fill_q  <= N_F;
                end else begin
                    // Consumed bits are not reused: start a fresh fill
                    window_q <= '0;
                    fill_q   <= '0;
                    state_q  <= FILL;
                end
            end else begin
                dout_q <= 1'b0;
                if (state_q == FILL) begin
                    fill_q  <= fill_inc_s;
                    state_q <= (fill_inc_s == N_F) ? HUNT : FILL;
                end else begin
                    fill_q  <= fill_q;
                    state_q <= state_q;
                end
            end
        end else begin
            dout_q <= 1'b0;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = sat_q;
    assign bus.armed     = armed_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two instances (wide and 2-bit counter) share one
// stimulus stream and are checked every cycle against a queue-based model.
module tb_seq_detect_param;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         d_en, d_load, d_ovl, d_valid, d_seq;
    logic [N-1:0] d_pat;

    seq_detect_param_if #(.N(N), .CNT_W(8)) bus_a ();
    seq_detect_param_if #(.N(N), .CNT_W(2)) bus_b ();

    assign bus_a.en = d_en;       assign bus_b.en = d_en;
    assign bus_a.load = d_load;   assign bus_b.load = d_load;
    assign bus_a.pattern_in = d_pat; assign bus_b.pattern_in = d_pat;
    assign bus_a.overlap_in = d_ovl; assign bus_b.overlap_in = d_ovl;
    assign bus_a.seq_valid = d_valid; assign bus_b.seq_valid = d_valid;
    assign bus_a.seq = d_seq;     assign bus_b.seq = d_seq;

    seq_detect_param #(.N(N), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    seq_detect_param #(.N(N), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int vectors;
    int miscompares;

    // Reference model: history of accepted bits since load or last consumed match
    bit  m_armed;
    int  m_pat;
    bit  m_ovl;
    bit  hist[$];
    int  m_cnt[2];
    int  m_max[2] = '{255, 3};
    bit  m_dout;

    task automatic model_reset();
        m_armed = 1'b0; m_pat = 0; m_ovl = 1'b0; hist.delete();
        m_cnt[0] = 0; m_cnt[1] = 0; m_dout = 1'b0;
    endtask

    task automatic model_edge();
        int v;
        m_dout = 1'b0;
        if (d_load) begin
            m_armed = 1'b1; m_pat = int'(d_pat); m_ovl = d_ovl;
            hist.delete(); m_cnt[0] = 0; m_cnt[1] = 0;
        end else if (m_armed && d_en && d_valid) begin
            hist.push_back(bit'(d_seq));
            if (hist.size() > N) void'(hist.pop_front());
            if (hist.size() == N) begin
                v = 0;
                for (int i = 0; i < N; i++) v = v * 2 + int'(hist[i]);
                if (v == m_pat) begin
                    m_dout = 1'b1;
                    for (int k = 0; k < 2; k++)
                        if (m_cnt[k] < m_max[k]) m_cnt[k] = m_cnt[k] + 1;
                    if (!m_ovl) hist.delete();
                end
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".a.dout"},  32'(bus_a.dout),      32'(m_dout));
        check({tag, ".a.cnt"},   32'(bus_a.match_cnt), 32'(m_cnt[0]));
        check({tag, ".a.sat"},   32'(bus_a.cnt_sat),   32'(m_cnt[0] == m_max[0]));
        check({tag, ".a.armed"}, 32'(bus_a.armed),     32'(m_armed));
        check({tag, ".b.dout"},  32'(bus_b.dout),      32'(m_dout));
        check({tag, ".b.cnt"},   32'(bus_b.match_cnt), 32'(m_cnt[1]));
        check({tag, ".b.sat"},   32'(bus_b.cnt_sat),   32'(m_cnt[1] == m_max[1]));
        check({tag, ".b.armed"}, 32'(bus_b.armed),     32'(m_armed));
    endtask

    // One clock: drive inputs away from the edge, update model, sample on negedge
    task automatic step(string tag, logic l, logic [N-1:0] p, logic o,
                        logic e, logic v, logic s);
        d_load = l; d_pat = p; d_ovl = o; d_en = e; d_valid = v; d_seq = s;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic stream(string tag, logic [31:0] bits, int len);
        logic [31:0] b;
        b = bits;
        for (int i = 0; i < len; i++)
            step(tag, 1'b0, d_pat, d_ovl, 1'b1, 1'b1, b[len-1-i]);
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge
    task automatic async_reset(string tag);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        check_all({tag, "_hold"});
        rst = 1'b1;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b0;
        d_en = 1'b0; d_load = 1'b0; d_pat = '0; d_ovl = 1'b0; d_valid = 1'b0; d_seq = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b1;

        // Bits before any load are ignored
        stream("idle", 32'b1011, 4);

        // Overlapping detection
        step("s1_load", 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
        stream("s1", 32'b1011011, 7);
        check("s1_total", 32'(bus_a.match_cnt), 32'd2);

        // Non-overlapping detection
        step("s2_load", 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0);
        stream("s2", 32'b1011011011, 10);
        check("s2_total", 32'(bus_a.match_cnt), 32'd2);

        // Fill gating with all-zero pattern
        step("s3_load", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        stream("s3_fill", 32'b000, 3);
        check("s3_nopulse_cnt", 32'(bus_a.match_cnt), 32'd0);
        stream("s3_first", 32'b0, 1);
        check("s3_first_dout", 32'(bus_a.dout), 32'd1);
        stream("s3_second", 32'b0, 1);
        check("s3_second_dout", 32'(bus_a.dout), 32'd1);

        // Qualification: valid gaps with garbage and en low mid-pattern
        step("s4_load", 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
        step("s4", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
        step("s4_gap", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
        step("s4", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step("s4_en0", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'(i));
        step("s4", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
        step("s4_gap", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        step("s4", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
        step("s4_gap", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
        stream("s4_tail", 32'b011, 3);
        check("s4_total", 32'(bus_a.match_cnt), 32'd2);

        // Saturation of the 2-bit counter
        step("s5_load", 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
        stream("s5", 32'b1111111, 7);
        check("s5_b_cnt", 32'(bus_b.match_cnt), 32'd3);
        check("s5_b_sat", 32'(bus_b.cnt_sat), 32'd1);
        check("s5_a_cnt", 32'(bus_a.match_cnt), 32'd4);
        step("s5_reload", 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
        check("s5_b_clr", 32'(bus_b.match_cnt), 32'd0);

        // Async reset mid-pattern, then the completing bit is ignored
        step("s6_load", 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
        stream("s6_pre", 32'b101, 3);
        async_reset("s6_rst");
        stream("s6_post", 32'b1, 1);
        check("s6_post_dout", 32'(bus_a.dout), 32'd0);

        // Load and valid bit together: the bit is dropped
        step("s6_ldv", 1'b1, 4'b1011, 1'b0, 1'b1, 1'b1, 1'b1);
        stream("s6_after", 32'b011, 3);
        check("s6_discard", 32'(bus_a.match_cnt), 32'd0);
        stream("s6_more", 32'b1011, 4);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd",
                     1'($urandom_range(0, 99) < 3),
                     4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 9) != 0),
                     1'($urandom_range(0, 9) < 7),
                     1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial sequence detector; successor to the fixed-pattern single-bit FSM detectors in this design.
- Pattern length is a parameter. The pattern is loaded at run time, and overlapping or non-overlapping detection is selectable.
- Input bits are qualified by a valid strobe. The block outputs a registered match pulse and a saturating match counter.
- Sits between a serial bit source and control/status logic.

Parameters:
- N, 4, pattern length in bits; legal range 2..32.
- CNT_W, 8, match counter width; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- en  input  1  accept enable; when 0, seq_valid is ignored and all state holds.
- load  input  1  pattern load strobe.
- pattern_in  input  N  pattern to detect; bit N-1 is the first expected bit.
- overlap_in  input  1  detection mode, captured on load: 1 = overlapping, 0 = non-overlapping.
- seq_valid  input  1  seq is a valid bit this cycle.
- seq  input  1  serial data bit.
- dout  output  1  one-cycle match pulse (registered).
- match_cnt  output  CNT_W  number of matches since the last load or reset; saturating.
- cnt_sat  output  1  match_cnt has reached all-ones.
- armed  output  1  a pattern is loaded (state is not IDLE).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; pattern register, shift window and fill count are all 0; overlap register=0.
  - dout=0, match_cnt=0, cnt_sat=0, armed=0.
  - Reset mid-stream aborts immediately; no pulse is generated from pre-reset bits.
- States:
  - IDLE: no pattern loaded; bits ignored; dout stays 0.
  - FILL: fill count is below N.
  - HUNT: window holds N valid bits.
- Load:
  - load=1 at a clock edge (any state, en don't-care) captures pattern_in and overlap_in.
  - It also clears the window, fill count and match_cnt/cnt_sat, and moves to FILL.
  - load has priority: a seq_valid bit in the same cycle is discarded.
- Accepted bit: en=1, seq_valid=1, load=0, state is FILL or HUNT.
  - The window shifts left with seq entering the LSB. The newest bit is the LSB, so pattern_in[0] is the last expected bit.
  - In FILL, the fill count increments. The state moves to HUNT when the count reaches N.
- Match:
  - Evaluated on the window including the just-accepted bit, and only when at least N bits have been accepted (fill count reaches N on this bit, or state is already HUNT).
  - A match is window == pattern over all N bits.
- dout latency:
  - dout=1 for exactly the one cycle after the edge that accepted the completing bit.
  - dout=0 in every other cycle, including cycles with no accepted bit.
- After a match with overlap=1: the window is kept and the state remains HUNT. The next accepted bit can complete another match.
- After a match with overlap=0: the window and fill count are cleared and the state goes to FILL. The next N accepted bits start fresh.
- Counter:
  - match_cnt increments by 1 on each match, registered on the same edge as dout.
  - At all-ones it holds, and cnt_sat=1 from that edge onward until load or reset.
- en=0 or seq_valid=0: the window, fill count and state hold; dout=0.
- pattern_in and overlap_in changes without load have no effect.
- All outputs are driven from registers; there are no combinational paths from inputs to outputs.

Test Plan:
1. N=4, load pattern_in=4'b1011 with overlap_in=1, then stream 1,0,1,1,0,1,1 with seq_valid=1 every cycle.
   -> dout pulses one cycle after bit 4 and after bit 7; match_cnt=2.
2. Same pattern with overlap_in=0, stream 1,0,1,1,0,1,1,0,1,1.
   -> pulses after bit 4 and after bit 10 only; match_cnt=2.
3. Fill gating: load pattern 4'b0000, send three 0s.
   -> dout stays 0 and the state is FILL.
   Then send a fourth 0 -> dout=1 for one cycle.
   Then send a fifth 0 with overlap=1 -> another pulse.
4. Qualification: interleave seq_valid=0 cycles carrying garbage seq values, and hold en=0 for 3 cycles mid-pattern.
   -> detection is identical to scenario 1; dout=0 during gap cycles.
5. Saturation: CNT_W=2, overlap=1, pattern 4'b1111, stream seven 1s (4 matches).
   -> match_cnt=3 and cnt_sat=1 after the 3rd match; dout still pulses on the 4th match.
   Then assert load -> match_cnt=0, cnt_sat=0.
6. Reset and priority:
   - Before any load, stream 1011 -> armed=0 and no dout.
   - Assert rst=0 asynchronously between clock edges after 3 matching bits -> outputs clear immediately; the 4th bit after reset release gives no pulse.
   - load and seq_valid in the same cycle -> the bit is discarded and the fill count is 0.
